// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal TX FIFO and CTS flow control.
// Frames: start, DATA_BITS LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 27_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          cts_n,
    output logic                          tx_pin,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST    = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  DATA_LAST    = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST    = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // ---------------------------------------------------------------- FIFO
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic                 fifo_empty, fifo_full;
    logic                 push, pop;
    logic [DATA_BITS-1:0] rd_data;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = tx_valid && !fifo_full;
    assign rd_data    = mem[rd_ptr_q[AW-1:0]];
    assign tx_ready   = !fifo_full;
    assign fifo_count = wr_ptr_q - rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------ CTS synchroniser
    logic cts_meta_q, cts_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    // ------------------------------------------------------------------ FSM
    state_e               state_q, state_d;
    logic [15:0]          baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 pin_q, pin_d;
    logic                 busy_q, busy_d;
    logic                 can_start, bit_end;

    assign can_start = !fifo_empty && !cts_sync_q;
    assign bit_end   = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;

        case (state_q)
            StIdle: begin
                baud_d = '0;
                bit_d  = '0;
            end
            default: begin
                baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
            end
        endcase

        case (state_q)
            StIdle: begin
                if (can_start) begin
                    state_d = StStart;
                    pop     = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // Decide in the last stop cycle so back-to-back frames have no gap.
                        if (can_start) begin
                            state_d = StStart;
                            pop     = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (pop) begin
            shift_d = rd_data;
            par_d   = (PARITY == 2) ? ~(^rd_data) : ^rd_data;
            baud_d  = '0;
            bit_d   = '0;
        end
    end

    // Pin and busy follow the current state, one register stage behind it.
    always_comb begin
        pin_d  = 1'b1;
        busy_d = (state_q != StIdle);
        case (state_q)
            StStart:  pin_d = 1'b0;
            StData:   pin_d = shift_q[0];
            StParity: pin_d = par_q;
            default:  pin_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            pin_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            pin_q   <= pin_d;
            busy_q  <= busy_d;
        end
    end

    assign tx_pin  = pin_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame vectors for several formats plus
// hand-written flow-control, back-to-back and reset sequences.
module tb_uart_tx_fifo;

    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned BAUD     = 100_000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cts_n;
    logic [7:0] drv_data;
    logic       drv_valid;
    int         sel;

    logic [3:0] val_v, pin_v, busy_v, ready_v;
    logic [4:0] cnt_v [4];
    logic       mon_pin, mon_busy, mon_ready;
    logic [4:0] mon_cnt;

    int errors = 0;
    int checks = 0;
    int busy_total = 0;

    always #5 clk = ~clk;

    assign val_v     = drv_valid ? (4'b0001 << sel) : 4'b0000;
    assign mon_pin   = pin_v[sel];
    assign mon_busy  = busy_v[sel];
    assign mon_ready = ready_v[sel];
    assign mon_cnt   = cnt_v[sel];

    always @(posedge clk) begin
        if (mon_busy) busy_total <= busy_total + 1;
    end

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .tx_data(drv_data), .tx_valid(val_v[0]),
        .tx_ready(ready_v[0]), .cts_n(cts_n), .tx_pin(pin_v[0]), .tx_busy(busy_v[0]),
        .fifo_count(cnt_v[0]));

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .tx_data(drv_data), .tx_valid(val_v[1]),
        .tx_ready(ready_v[1]), .cts_n(cts_n), .tx_pin(pin_v[1]), .tx_busy(busy_v[1]),
        .fifo_count(cnt_v[1]));

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .tx_data(drv_data), .tx_valid(val_v[2]),
        .tx_ready(ready_v[2]), .cts_n(cts_n), .tx_pin(pin_v[2]), .tx_busy(busy_v[2]),
        .fifo_count(cnt_v[2]));

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(16)) u_7n2 (
        .clk(clk), .rst_n(rst_n), .tx_data(drv_data[6:0]), .tx_valid(val_v[3]),
        .tx_ready(ready_v[3]), .cts_n(cts_n), .tx_pin(pin_v[3]), .tx_busy(busy_v[3]),
        .fifo_count(cnt_v[3]));

    typedef struct {
        int          sel;
        logic [7:0]  data;
        int          nbits;
        logic [11:0] frame;   // bit i = i-th serial bit, start bit first
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic push(input logic [7:0] d);
        check("push_ready", int'(mon_ready), 1);
        drv_data  = d;
        drv_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
    endtask

    // Returns negedges elapsed until tx_pin is seen low, or -1 on timeout.
    task automatic wait_start(input int limit, output int lat);
        lat = -1;
        for (int c = 1; c <= limit && lat < 0; c++) begin
            @(negedge clk);
            if (mon_pin == 1'b0) lat = c;
        end
    endtask

    task automatic wait_drain(input int limit, output int ok);
        ok = 0;
        for (int c = 0; c < limit && ok == 0; c++) begin
            @(negedge clk);
            if (!mon_busy && mon_cnt == 5'd0) ok = 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0, lat, ok, bad;
        logic [11:0] frame;

        vecs[0] = '{0, 8'hA5, 10, 12'h34A};
        vecs[1] = '{0, 8'h00, 10, 12'h200};
        vecs[2] = '{0, 8'hFF, 10, 12'h3FE};
        vecs[3] = '{0, 8'h81, 10, 12'h302};
        vecs[4] = '{1, 8'h07, 11, 12'h60E};   // even parity 1
        vecs[5] = '{1, 8'h03, 11, 12'h406};   // even parity 0
        vecs[6] = '{2, 8'h07, 11, 12'h40E};   // odd parity 0
        vecs[7] = '{2, 8'h03, 11, 12'h606};   // odd parity 1
        vecs[8] = '{3, 8'h41, 10, 12'h382};   // 7N2

        rst_n = 1'b0; cts_n = 1'b0; drv_valid = 1'b0; drv_data = '0; sel = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_pin[%0d]", i), int'(pin_v[i]), 1);
            check($sformatf("reset_busy[%0d]", i), int'(busy_v[i]), 0);
            check($sformatf("reset_ready[%0d]", i), int'(ready_v[i]), 1);
            check($sformatf("reset_count[%0d]", i), int'(cnt_v[i]), 0);
        end

        // Frame vectors
        for (int v = 0; v < 9; v++) begin
            sel = vecs[v].sel;
            t0  = busy_total;
            push(vecs[v].data);
            @(negedge clk);
            check($sformatf("v%0d_pin_before_start", v), int'(mon_pin), 1);
            @(negedge clk);
            check($sformatf("v%0d_start_at_n2", v), int'(mon_pin), 0);
            frame = '0;
            repeat (5) @(negedge clk);
            frame[0] = mon_pin;
            for (int b = 1; b < vecs[v].nbits; b++) begin
                repeat (10) @(negedge clk);
                frame[b] = mon_pin;
            end
            check($sformatf("v%0d_frame", v), int'(frame), int'(vecs[v].frame));
            repeat (10) @(negedge clk);
            check($sformatf("v%0d_busy_end", v), int'(mon_busy), 0);
            check($sformatf("v%0d_busy_cycles", v), busy_total - t0, vecs[v].nbits * 10);
        end

        // CTS held off: fill FIFO, 17th word held
        sel = 0;
        cts_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        check("full_count", int'(mon_cnt), 16);
        check("full_ready", int'(mon_ready), 0);
        drv_data = 8'hEE; drv_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mon_pin != 1'b1 || mon_busy) bad++;
        end
        drv_valid = 1'b0;
        check("full_17th_held", int'(mon_cnt), 16);
        check("cts_hold_line_idle", bad, 0);
        t0 = busy_total;
        cts_n = 1'b0;
        wait_start(10, lat);
        check_range("cts_release_latency", lat, 3, 5);
        check("ready_after_pop", int'(mon_ready), 1);
        check("count_after_pop", int'(mon_cnt), 15);
        wait_drain(3000, ok);
        check("drain16_done", ok, 1);
        check("drain16_busy_cycles", busy_total - t0, 1600);

        // Back-to-back frames
        cts_n = 1'b1;
        repeat (4) @(negedge clk);
        push(8'h55); push(8'h0F); push(8'hC3);
        t0 = busy_total;
        cts_n = 1'b0;
        wait_start(10, lat);
        check_range("b2b_start_latency", lat, 3, 5);
        bad = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k < 300 && !mon_busy) bad++;
            if (k == 99 || k == 199) check($sformatf("b2b_stop_k%0d", k), int'(mon_pin), 1);
            if (k == 100 || k == 200) check($sformatf("b2b_start_k%0d", k), int'(mon_pin), 0);
        end
        check("b2b_busy_gaps", bad, 0);
        check("b2b_busy_end", int'(mon_busy), 0);
        check("b2b_busy_cycles", busy_total - t0, 300);

        // CTS raised mid-frame
        push(8'hA5); push(8'h3C);
        wait_start(10, lat);
        check_range("mid_start_latency", lat, 1, 3);
        repeat (40) @(negedge clk);
        cts_n = 1'b1;
        bad = 0;
        for (int k = 41; k <= 150; k++) begin
            @(negedge clk);
            if (k <= 99 && !mon_busy) bad++;
            if (k >= 100 && (mon_busy || mon_pin != 1'b1)) bad++;
        end
        check("mid_frame_complete_then_hold", bad, 0);
        check("mid_count_held", int'(mon_cnt), 1);
        cts_n = 1'b0;
        wait_start(10, lat);
        check_range("mid_release_latency", lat, 3, 5);
        wait_drain(300, ok);
        check("mid_drain_done", ok, 1);

        // Reset mid-frame on the 7N2 instance
        sel = 3;
        push(8'h41); push(8'h7F);
        wait_start(10, lat);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_pin", int'(mon_pin), 1);
        check("rst_busy", int'(mon_busy), 0);
        check("rst_ready", int'(mon_ready), 1);
        check("rst_count", int'(mon_cnt), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (mon_pin != 1'b1 || mon_busy) bad++;
        end
        check("rst_no_resume", bad, 0);
        check("rst_count_after", int'(mon_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter for the Tang Nano 4K Sobel design.
- Supports 5–9 data bits, optional even/odd parity, and 1 or 2 stop bits.
- Has an internal TX FIFO and a CTS hardware flow-control input.
- Decouples pixel/debug producers from the serial line, so bursts can be queued without per-byte stalls.

Parameters:
- CLK_FREQ, 27_000_000: clock frequency in Hz.
- BAUD_RATE, 115200: line rate. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer truncation, must be ≥ 4).
- DATA_BITS, 8: payload width, legal 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: entries, power of 2, ≥ 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- tx_data  input  DATA_BITS  word to queue.
- tx_valid  input  1  producer has a word.
- tx_ready  output  1  FIFO not full. A word is accepted when tx_valid && tx_ready at a rising edge.
- cts_n  input  1  clear-to-send, active-low, asynchronous to clk.
- tx_pin  output  1  serial line, idle high.
- tx_busy  output  1  a frame is in progress.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued words, excluding the frame in flight.

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - tx_pin = 1, tx_busy = 0, tx_ready = 1, fifo_count = 0.
  - FIFO pointers 0, state IDLE, baud counter 0, bit index 0.
  - CTS synchroniser flops = 1 (not clear).
- FIFO:
  - Registered write/read pointers, one extra bit for full/empty; tx_ready = !full.
  - Push and pop in the same cycle: count unchanged, both operations take effect.
  - Push while full is impossible (ready low); the data is ignored and the producer holds.
- CTS: cts_n passes through a 2-FF synchroniser. The synchronised value is checked only in IDLE (frame boundary). Deasserting it mid-frame never truncates the current frame.
- Frame format, per bit period of exactly CLKS_PER_BIT cycles:
  - start bit 0;
  - DATA_BITS data bits, LSB first;
  - parity bit if PARITY ≠ 0 (even = XOR of data bits, odd = its inverse);
  - STOP_BITS stop bits of 1.
- Frame length = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bit periods.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when FIFO non-empty and synchronised CTS is low. The word is popped into a shift register the same edge.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY (or STOP if PARITY = 0) after DATA_BITS periods.
  - PARITY → STOP after 1 period.
  - STOP → IDLE after STOP_BITS periods.
- tx_pin is registered and is the only path to the pin.
- Latency: a word pushed into an empty FIFO at edge N (CTS already low and stable) pops at edge N+1. tx_pin goes low at edge N+2.
- Back-to-back:
  - The IDLE decision is made in the last cycle of the final stop bit, so the next start bit follows the final stop period with no idle gap.
  - IDLE is occupied for 0 cycles when more data is queued and CTS is low.
- tx_busy is high from the edge tx_pin goes low (start) until the end of the last stop period.
- Baud counter is 16 bits and wraps to 0 at CLKS_PER_BIT−1.
- Reset asserted mid-frame: all outputs go to reset values immediately, queued data is discarded, and no partial frame resumes after release.

Test Plan (bench overrides CLK_FREQ=1_000_000, BAUD_RATE=100_000 → 10 cycles/bit, FIFO_DEPTH=16 unless stated):
- 8N1, cts_n=0, push 0xA5: tx_pin sequence 0,1,0,1,0,0,1,0,1,1, each held 10 cycles. Start bit begins 2 edges after the push. tx_busy high for 100 cycles.
- 8E1, push 0x07 then 0x03: parity bits 1 then 0, frames 110 cycles each. PARITY=2 with 0x07 gives parity 0.
- cts_n=1, push 17 words: first 16 accepted, fifo_count=16, tx_ready=0, 17th held. tx_pin stays 1. Drop cts_n: first start bit within 5 cycles, tx_ready returns to 1 after the first pop.
- 3 words queued, cts_n=0: three 8N1 frames contiguous, tx_pin never high longer than one stop period between frames, total 300 cycles of tx_busy.
- cts_n raised at cycle 40 of a frame: frame completes all 100 cycles, next frame does not start until cts_n low plus synchroniser delay.
- DATA_BITS=7, STOP_BITS=2, push 0x41: 10 bit periods (0,1,0,0,0,0,0,1,1,1). rst_n pulsed low mid-frame: tx_pin=1, fifo_count=0, tx_ready=1 immediately, and no frame resumes after release.
